// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receiver.
//   state_e     : receiver FSM states
//   ERR_CNT_W   : width of the optional error-frame counter
//   ERR_CNT_MAX : saturation value of that counter
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam int ERR_CNT_W   = 8;
    localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// parity_acc: 1-bit XOR accumulator for the parity link.
//   clk_i   : clock (rising edge)
//   rst_n_i : synchronous active-low reset, loads ODD
//   init_i  : load ODD (takes priority over en_i)
//   en_i    : acc ^= bit_i
//   bit_i   : bit to fold into the accumulator
//   acc_o   : current accumulator value
module parity_acc #(
    parameter bit ODD = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic init_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (init_i) begin
            acc_d = ODD;
        end else if (en_i) begin
            acc_d = acc_q ^ bit_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= ODD;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receives start/data/parity/stop frames, one bit per
// strobe, LSB first, and checks parity against a running XOR of the data.
//   clk_i        : clock (rising edge)
//   rst_n_i      : synchronous active-low reset
//   sin_valid_i  : qualifies sin_i for one cycle
//   sin_i        : serial bit, idle level 1
//   dout_o       : last received data word (held)
//   dout_valid_o : one-cycle pulse when a frame completes
//   par_err_o    : parity error of the frame in dout_o
//   frame_err_o  : stop bit was 0 for the frame in dout_o
//   busy_o       : frame in progress
//   err_cnt_o    : saturating error-frame count, present only when
//                  SERIAL_PARITY_RX_ERRCNT_EN is defined
//
// state  | meaning
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | shifting in DATA_W data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit; frame is published on its strobe
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sin_valid_i,
    input  logic              sin_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              par_err_o,
    output logic              frame_err_o,
    output logic              busy_o
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              par_err_q, par_err_d;
    logic              frame_err_q, frame_err_d;
    logic              acc_init;
    logic              acc_en;
    logic              acc;
    logic [DATA_W:0]   shift_in;

    parity_acc #(
        .ODD (ODD)
    ) u_parity_acc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (acc_init),
        .en_i    (acc_en),
        .bit_i   (sin_i),
        .acc_o   (acc)
    );

    // New bit enters at the MSB so that after DATA_W shifts the first
    // (LSB-first) bit lands in bit 0; written this way to stay legal for DATA_W=1.
    assign shift_in = {sin_i, shreg_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        par_err_d    = par_err_q;
        frame_err_d  = frame_err_q;
        acc_init     = 1'b0;
        acc_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (sin_valid_i && !sin_i) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    acc_init = 1'b1;
                end
            end
            DATA: begin
                if (sin_valid_i) begin
                    shreg_d = shift_in[DATA_W:1];
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sin_valid_i) begin
                    perr_d  = acc ^ sin_i;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Publishing on the stop strobe puts the FSM back in IDLE during
                // the pulse cycle, so a start bit there is accepted.
                if (sin_valid_i) begin
                    dout_d       = shreg_q;
                    par_err_d    = perr_q;
                    frame_err_d  = ~sin_i;
                    dout_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Counts from the published flags, so the count moves one cycle after
    // the pulse; a frame with both errors counts once.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= '0;
        end else if (dout_valid_q && (par_err_q || frame_err_q) &&
                     (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX))) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign par_err_o    = par_err_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity
// instance share the serial line. Error-counter checks are active when
// SERIAL_PARITY_RX_ERRCNT_EN is defined.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       sin_valid;
    logic       sin;

    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    logic [7:0] ecnt_e, ecnt_o;
`endif

    int vec_cnt    = 0;
    int miscompare = 0;
    int cyc        = 0;
    int pulse_cnt  = 0;
    int last_pulse = 0;
    int prev_pulse = 0;

    serial_parity_rx #(.DATA_W(8), .ODD(1'b0)) u_dut_even (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .sin_valid_i  (sin_valid),
        .sin_i        (sin),
        .dout_o       (dout_e),
        .dout_valid_o (dv_e),
        .par_err_o    (perr_e),
        .frame_err_o  (ferr_e),
        .busy_o       (busy_e)
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        ,
        .err_cnt_o    (ecnt_e)
`endif
    );

    serial_parity_rx #(.DATA_W(8), .ODD(1'b1)) u_dut_odd (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .sin_valid_i  (sin_valid),
        .sin_i        (sin),
        .dout_o       (dout_o),
        .dout_valid_o (dv_o),
        .par_err_o    (perr_o),
        .frame_err_o  (ferr_o),
        .busy_o       (busy_o)
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        ,
        .err_cnt_o    (ecnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv_e) begin
            pulse_cnt  = pulse_cnt + 1;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            miscompare++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic strobe(input logic b);
        sin_valid = 1'b1;
        sin       = b;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin       = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends start, 8 data bits LSB first, parity, stop; up to max_gap
    // unqualified cycles are inserted between bits (never after the stop).
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                              input int max_gap);
        strobe(1'b0);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        for (int i = 0; i < 8; i++) begin
            strobe(data[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        strobe(par);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        strobe(stp);
    endtask

    initial begin
        int pc;
        rst_n     = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_dout", {24'd0, dout_e}, 32'h0);
        chk("rst_dv", {31'd0, dv_e}, 32'h0);
        chk("rst_perr", {31'd0, perr_e}, 32'h0);
        chk("rst_ferr", {31'd0, ferr_e}, 32'h0);
        chk("rst_busy", {31'd0, busy_e}, 32'h0);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("rst_ecnt", {24'd0, ecnt_e}, 32'h0);
`endif

        // idle-line 1s keep the receiver idle
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b1);
        chk("idle_busy", {31'd0, busy_e}, 32'h0);

        // 0xA5 (four ones), even parity 0, good stop, continuous strobes
        strobe(1'b0);
        chk("a5_busy", {31'd0, busy_e}, 32'h1);
        for (int i = 0; i < 8; i++) strobe(i[0] ? ((8'hA5 >> i) & 8'h1) != 0 : ((8'hA5 >> i) & 8'h1) != 0);
        chk("a5_dv_early", {31'd0, dv_e}, 32'h0);
        strobe(1'b0);
        strobe(1'b1);
        chk("a5_dv", {31'd0, dv_e}, 32'h1);
        chk("a5_dout", {24'd0, dout_e}, 32'hA5);
        chk("a5_perr", {31'd0, perr_e}, 32'h0);
        chk("a5_ferr", {31'd0, ferr_e}, 32'h0);
        chk("a5_busy_after", {31'd0, busy_e}, 32'h0);
        idle(1);
        chk("a5_dv_drop", {31'd0, dv_e}, 32'h0);
        chk("a5_dout_hold", {24'd0, dout_e}, 32'hA5);

        // 0x07 (three ones) with parity 0: even error, odd fine
        send_frame(8'h07, 1'b0, 1'b1, 0);
        chk("p07_dout", {24'd0, dout_e}, 32'h07);
        chk("p07_perr", {31'd0, perr_e}, 32'h1);
        chk("p07_perr_odd", {31'd0, perr_o}, 32'h0);
        idle(1);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("p07_ecnt", {24'd0, ecnt_e}, 32'h1);
`endif
        send_frame(8'h07, 1'b1, 1'b1, 0);
        chk("p07ok_perr", {31'd0, perr_e}, 32'h0);
        idle(1);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("p07ok_ecnt", {24'd0, ecnt_e}, 32'h1);
`endif

        // 0x3C with bad stop bit and gapped strobes
        send_frame(8'h3C, 1'b0, 1'b0, 5);
        chk("f3c_dv", {31'd0, dv_e}, 32'h1);
        chk("f3c_dout", {24'd0, dout_e}, 32'h3C);
        chk("f3c_ferr", {31'd0, ferr_e}, 32'h1);
        chk("f3c_perr", {31'd0, perr_e}, 32'h0);
        idle(1);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("f3c_ecnt", {24'd0, ecnt_e}, 32'h2);
`endif

        // reset after four data bits
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        chk("mid_busy", {31'd0, busy_e}, 32'h1);
        pc = pulse_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy_e}, 32'h0);
        chk("mid_rst_dout", {24'd0, dout_e}, 32'h0);
        strobe(1'b1);
        strobe(1'b1);
        idle(3);
        chk("mid_no_dv", pulse_cnt, pc);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("mid_rst_ecnt", {24'd0, ecnt_e}, 32'h0);
`endif

        // back-to-back: second start bit lands in the first pulse cycle
        send_frame(8'h12, 1'b0, 1'b1, 0);
        chk("b2b_dv1", {31'd0, dv_e}, 32'h1);
        chk("b2b_dout1", {24'd0, dout_e}, 32'h12);
        send_frame(8'h34, 1'b1, 1'b1, 0);
        chk("b2b_dv2", {31'd0, dv_e}, 32'h1);
        chk("b2b_dout2", {24'd0, dout_e}, 32'h34);
        chk("b2b_perr2", {31'd0, perr_e}, 32'h0);
        idle(1);
        chk("b2b_spacing", last_pulse - prev_pulse, 32'd11);

        // 0x00 with parity 1: odd receiver happy, even receiver flags it
        send_frame(8'h00, 1'b1, 1'b1, 0);
        chk("odd_dout", {24'd0, dout_o}, 32'h00);
        chk("odd_perr", {31'd0, perr_o}, 32'h0);
        chk("odd_perr_even", {31'd0, perr_e}, 32'h1);
        idle(1);

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        chk("sat_start", {24'd0, ecnt_e}, 32'h1);
        for (int i = 0; i < 260; i++) send_frame(8'h07, 1'b0, 1'b1, 0);
        idle(2);
        chk("sat_ecnt", {24'd0, ecnt_e}, 32'd255);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        idle(2);
        chk("sat_hold", {24'd0, ecnt_e}, 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver with parity check. It is the receive end of the team's XOR-based parity link. It deserialises start / data / parity / stop frames sampled one bit per strobe and checks the received parity bit against a running XOR of the data bits. It presents the byte with per-frame parity and framing error flags. It sits between the line-sampling logic and downstream byte consumers.

## Interface
- DATA_W, 8, number of data bits per frame (≥1)
- ODD, 0, parity sense: 0 = even (data ones + parity bit is even), 1 = odd
- CLK  input  1  single clock; all logic on rising edge
- RST_N  input  1  synchronous, active-low reset
- SIN_VALID  input  1  qualifies SIN for one cycle (one bit per strobe)
- SIN  input  1  serial bit, LSB first; idle level 1
- DOUT  output  DATA_W  last received data word
- DOUT_VALID  output  1  one-cycle pulse: new frame completed
- PAR_ERR  output  1  parity error for the frame in DOUT
- FRAME_ERR  output  1  stop bit was 0 for the frame in DOUT
- BUSY  output  1  frame in progress (FSM not IDLE)
- ERR_CNT  output  8  error frame count (only with SERIAL_PARITY_RX_ERRCNT_EN)

## Operation
- Clock and reset: one clock, CLK. Reset is synchronous, active-low on RST_N.
- Reset values: FSM=IDLE, DOUT=0, DOUT_VALID=0, PAR_ERR=0, FRAME_ERR=0, BUSY=0, ERR_CNT=0, bit counter=0, parity accumulator=ODD.
- Bits are consumed only in cycles with SIN_VALID=1. With SIN_VALID=0, all state holds; gaps of any length are legal.
- FSM states:
  - IDLE: on SIN_VALID with SIN=1, stay (idle line). On SIN_VALID with SIN=0 (start bit), go to DATA; clear counter; set acc=ODD.
  - DATA: each strobe does shreg={SIN,shreg[DATA_W-1:1]}, acc^=SIN, count++. After the DATA_W-th bit, go to PARITY.
  - PARITY: on strobe, latch perr = acc^SIN; go to STOP.
  - STOP: on strobe, latch ferr = ~SIN. Next edge: DOUT<=shreg, PAR_ERR<=perr, FRAME_ERR<=ferr, DOUT_VALID<=1; go to IDLE.
- Frame output:
  - A frame with a framing error is still delivered (DOUT_VALID=1, FRAME_ERR=1). The FSM returns to IDLE and does not resynchronise further.
  - DOUT, PAR_ERR and FRAME_ERR hold until the next frame completes. DOUT_VALID is high for exactly one cycle.
- BUSY=1 in DATA, PARITY and STOP.
- Reset mid-frame discards the partial frame and returns to IDLE with reset values. No DOUT_VALID is produced.

## Timing
- Latency: DOUT_VALID rises on the edge after the cycle holding the stop-bit strobe.
- Back-to-back frames: the FSM is in IDLE in the DOUT_VALID cycle. A start-bit strobe in that same cycle is accepted.
- Minimum frame time is DATA_W+3 strobes. With SIN_VALID held high, that is DATA_W+3 cycles.
- No backpressure. The consumer must take DOUT in the DOUT_VALID cycle or read the held value before the next completion.

## Configuration
- SERIAL_PARITY_RX_ERRCNT_EN defined:
  - ERR_CNT port and an 8-bit saturating counter are present.
  - The counter increments in the DOUT_VALID cycle when PAR_ERR|FRAME_ERR for that frame; a frame with both errors counts once.
  - It sticks at 255 and clears only on reset.
- Undefined: no ERR_CNT port and no counter logic. All other behaviour is identical.

## Structure
- Package serial_parity_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP}
  - ERR_CNT_W=8
  - ERR_CNT_MAX=255
- Sub-module parity_acc: 1-bit XOR accumulator with init (load ODD) and enable (acc^=bit) inputs.
- Top-level holds the FSM, shift register, counter and output registers.

## Test plan
- Valid frame, DATA_W=8, ODD=0: send 0, 0xA5 LSB first, parity 0, stop 1 with SIN_VALID continuous. Required: DOUT=0xA5, DOUT_VALID one cycle after the stop strobe, PAR_ERR=0, FRAME_ERR=0.
- Parity error: send 0x07 with parity 0. Required: DOUT=0x07, PAR_ERR=1, ERR_CNT=1. Then 0x07 with parity 1 gives PAR_ERR=0 and ERR_CNT stays 1.
- Framing error and gapped input:
  - Send 0x3C with stop=0 and 0–5 idle cycles of SIN_VALID=0 between bits. Required: DOUT=0x3C, FRAME_ERR=1.
  - Idle 1s in IDLE keep BUSY=0.
- Reset mid-frame and back-to-back:
  - Drop RST_N for one cycle after 4 data bits. Required: BUSY=0, no DOUT_VALID.
  - Then send frames 0x12 and 0x34 with the second start bit in the DOUT_VALID cycle. Required: both delivered, DOUT_VALID pulses 11 cycles apart.
- ODD=1 and counter saturation:
  - 0x00 with parity 1 gives PAR_ERR=0.
  - 260 frames with parity errors give ERR_CNT=255 (macro defined).
